// File: rtl/cnn_uart_pkg.sv
// cnn_uart_pkg: constants and types shared by the UART nibble loader blocks.
//   NIB_W        - width of one received UART nibble
//   C_DEPTH_DEF  - default frame depth in words (28x28 image)
//   C_ADDRW_DEF  - default buffer address width
//   state_t      - loader FSM state encoding (2-bit)
package cnn_uart_pkg;
  localparam int NIB_W       = 4;
  localparam int C_DEPTH_DEF = 784;
  localparam int C_ADDRW_DEF = 10;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_COLLECT = 2'd1,
    S_WRITE   = 2'd2,
    S_DONE    = 2'd3
  } state_t;
endpackage

// File: rtl/uart_nibble_loader_shifter.sv
// nibble_shifter: packs received nibbles into a word, first nibble in the
// least-significant position.
//   clk, rst     - clock, synchronous active-high reset
//   clr          - synchronous clear (frame resynchronisation)
//   din_i        - received nibble, valid with tick_i
//   tick_i       - one-cycle strobe per received nibble
//   shreg_o      - packing shift register
//   partial_o    - at least one nibble of the current word held
//   word_done_o  - this tick completes a word (combinational)
module nibble_shifter
  import cnn_uart_pkg::*;
#(
  parameter int c_nibbles_per_word = 2
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  clr,
  input  logic [NIB_W-1:0]                      din_i,
  input  logic                                  tick_i,
  output logic [NIB_W*c_nibbles_per_word-1:0]   shreg_o,
  output logic                                  partial_o,
  output logic                                  word_done_o
);
  localparam int W  = NIB_W * c_nibbles_per_word;
  localparam int CW = (c_nibbles_per_word > 1) ? $clog2(c_nibbles_per_word) : 1;
  localparam logic [CW-1:0] LAST = CW'(c_nibbles_per_word - 1);

  logic [W-1:0]  shreg;
  logic [W-1:0]  shreg_nxt;
  logic [CW-1:0] nibcnt;

  // New nibble enters at the top; after a full word the first one sits in [3:0].
  generate
    if (c_nibbles_per_word == 1) begin : g_single
      assign shreg_nxt = din_i;
    end else begin : g_multi
      assign shreg_nxt = {din_i, shreg[W-1:NIB_W]};
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      shreg  <= '0;
      nibcnt <= '0;
    end else if (tick_i) begin
      shreg  <= shreg_nxt;
      nibcnt <= (nibcnt == LAST) ? '0 : nibcnt + CW'(1);
    end
  end

  assign shreg_o     = shreg;
  assign partial_o   = (nibcnt != '0);
  assign word_done_o = tick_i && (nibcnt == LAST);
endmodule

// File: rtl/uart_nibble_loader.sv
// uart_nibble_loader: packs UART nibbles into words and writes them to the
// image/weight buffer at auto-incrementing addresses, flagging each full frame.
//   clk, rst        - clock, synchronous active-high reset
//   din_i           - received nibble, valid with rx_done_tick_i
//   rx_done_tick_i  - one-cycle strobe per nibble
//   wr_en_o         - buffer write strobe
//   wr_addr_o       - buffer write address (holds last value when idle)
//   wr_data_o       - packed word (holds last value when idle)
//   frame_done_o    - one-cycle pulse after the last word of a frame
//   busy_o          - frame partially loaded
//   frame_cnt_o     - completed frames, wraps at 256
// Optional macro UART_LOADER_TIMEOUT_EN: idle-gap timeout of c_timeout cycles
// that discards a partial frame.
module uart_nibble_loader
  import cnn_uart_pkg::*;
#(
  parameter int c_nibbles_per_word = 2,
  parameter int c_depth            = C_DEPTH_DEF,
  parameter int c_addrw            = C_ADDRW_DEF,
  parameter int c_timeout          = 200_000
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic [NIB_W-1:0]                    din_i,
  input  logic                                rx_done_tick_i,
  output logic                                wr_en_o,
  output logic [c_addrw-1:0]                  wr_addr_o,
  output logic [NIB_W*c_nibbles_per_word-1:0] wr_data_o,
  output logic                                frame_done_o,
  output logic                                busy_o,
  output logic [7:0]                          frame_cnt_o
);
  localparam int W = NIB_W * c_nibbles_per_word;
  localparam logic [c_addrw-1:0] LAST_ADDR = c_addrw'(c_depth - 1);

  state_t             state;
  state_t             state_nxt;
  logic [W-1:0]       shreg;
  logic               partial;
  logic               word_done;
  logic               timeout;
  logic               pend;
  logic [c_addrw-1:0] addr;
  logic [c_addrw-1:0] last_addr;
  logic [W-1:0]       last_data;
  logic [7:0]         frame_cnt;
  logic               at_last;

  nibble_shifter #(
    .c_nibbles_per_word (c_nibbles_per_word)
  ) u_shifter (
    .clk         (clk),
    .rst         (rst),
    .clr         (timeout),
    .din_i       (din_i),
    .tick_i      (rx_done_tick_i),
    .shreg_o     (shreg),
    .partial_o   (partial),
    .word_done_o (word_done)
  );

  assign at_last = (addr == LAST_ADDR);

`ifdef UART_LOADER_TIMEOUT_EN
  localparam int GW = $clog2(c_timeout) + 1;
  logic [GW-1:0] gap;

  // A tick in the same cycle wins over the timeout, so no nibble is dropped.
  always_ff @(posedge clk) begin
    if (rst || !busy_o || rx_done_tick_i) gap <= '0;
    else                                  gap <= gap + GW'(1);
  end

  assign timeout = busy_o && !rx_done_tick_i && (gap == GW'(c_timeout - 1));
`else
  assign timeout = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE, S_COLLECT: begin
        if (word_done)           state_nxt = S_WRITE;
        else if (rx_done_tick_i) state_nxt = S_COLLECT;
      end
      S_WRITE: begin
        if (at_last)             state_nxt = S_DONE;
        else if (word_done)      state_nxt = S_WRITE;
        else                     state_nxt = S_IDLE;
      end
      S_DONE: begin
        if (word_done || pend)   state_nxt = S_WRITE;
        else                     state_nxt = S_IDLE;
      end
      default:                   state_nxt = S_IDLE;
    endcase
    if (timeout) state_nxt = S_IDLE;
  end

  // A word completed during the final write of a frame (single-nibble words
  // only) is parked until S_DONE has been signalled.
  always_ff @(posedge clk) begin
    if (rst || timeout)                               pend <= 1'b0;
    else if (state == S_WRITE && at_last && word_done) pend <= 1'b1;
    else if (state == S_DONE)                          pend <= 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst || timeout)        addr <= '0;
    else if (state == S_WRITE) addr <= at_last ? '0 : addr + c_addrw'(1);
  end

  // Write-port hold registers keep the last word/address visible between writes.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_data <= '0;
      last_addr <= '0;
    end else if (state == S_WRITE) begin
      last_data <= shreg;
      last_addr <= addr;
    end
  end

  always_ff @(posedge clk) begin
    if (rst)                  frame_cnt <= '0;
    else if (state == S_DONE) frame_cnt <= frame_cnt + 8'd1;
  end

  assign wr_en_o      = (state == S_WRITE);
  assign wr_data_o    = wr_en_o ? shreg : last_data;
  assign wr_addr_o    = wr_en_o ? addr  : last_addr;
  assign frame_done_o = (state == S_DONE);
  assign busy_o       = (addr != '0) || partial;
  assign frame_cnt_o  = frame_cnt;
endmodule
